cv32e40p_apu_shared_arbiter: RTL and testbench
==============================================

Name: cv32e40p_apu_shared_arbiter

Overview:
Shares one fixed-latency APU (FPU) pipeline between NB_CORES requesters.
- Round-robin arbitration over requesters.
- Reserves the single APU result port per cycle using a latency reservation table, so two results never collide.
- Routes each returning result to the requester that issued it.
- Sits between the cores' APU request interfaces and the shared APU, inside the cluster shared-FPU wrapper.

Parameters:
NB_CORES, 4, number of requesters (2..8)
NARGS, 3, operands per request; matches the package APU_NARGS_CPU
WOP, 6, opcode width; matches APU_WOP_CPU
NDSFLAGS, 15, downstream flag width; matches APU_NDSFLAGS_CPU
NUSFLAGS, 5, upstream result-flag width; matches APU_NUSFLAGS_CPU

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
core_req_i  in  NB_CORES  per-core request
core_gnt_o  out  NB_CORES  per-core grant; same-cycle, one-hot or zero
core_lat_class_i  in  2*NB_CORES  per-core latency class: 0 addsub, 1 mult, 2 cast, 3 mac
core_op_i  in  WOP*NB_CORES  per-core opcode
core_operands_i  in  32*NARGS*NB_CORES  per-core operands
core_flags_i  in  NDSFLAGS*NB_CORES  per-core flags
core_rvalid_o  out  NB_CORES  per-core result valid, one-hot or zero
core_result_o  out  32  result, broadcast to all cores
core_rflags_o  out  NUSFLAGS  result flags, broadcast to all cores
apu_req_o  out  1  issue to APU
apu_op_o  out  WOP  muxed opcode
apu_lat_class_o  out  2  muxed latency class
apu_operands_o  out  32*NARGS  muxed operands
apu_flags_o  out  NDSFLAGS  muxed flags
apu_rvalid_i  in  1  APU result valid
apu_result_i  in  32  APU result
apu_rflags_i  in  NUSFLAGS  APU result flags
protocol_err_o  out  1  sticky: apu_rvalid_i disagrees with the reservation
stall_cnt_o  out  32  conflict-stall counter; see Optional Feature

Behaviour:
Latency and reservation table
- Latency L(class) = PIPE_REG_ADDSUB / PIPE_REG_MULT / PIPE_REG_CAST / PIPE_REG_MAC = 1 / 1 / 1 / 2.
- Issue at cycle t means the result arrives at cycle t+L.
- MAX_LAT = 2. Table entries occ[0..MAX_LAT], each holding a valid bit and an owner id of $clog2(NB_CORES) bits.
- occ[k] means "result due k cycles from now"; occ[0] means due this cycle.
- Per cycle: occ'[k] = occ[k+1] for k < MAX_LAT; occ'[MAX_LAT] = 0.
- An issue with latency L additionally sets occ'[L-1] with the winner's id.

Arbitration (combinational)
- Requester i is eligible when core_req_i[i] is set and occ[L_i] is empty.
- Winner: the first eligible requester scanning from rr_ptr upward, modulo NB_CORES.
- core_gnt_o[winner] = 1 and apu_req_o = 1 in the same cycle. The mux selects the winner's op, class, operands and flags; outputs are 0 when there is no winner.
- rr_ptr is registered and updates to winner+1 (wrapping) only on a grant; otherwise it holds.
- A requester blocked by a slot conflict is skipped this cycle and is not granted; it keeps requesting.
- Back-to-back grants are allowed every cycle.
- Interaction at the same target cycle: a mac issued at t reserves the same cycle (t+2) as an addsub issued at t+1. The addsub is therefore stalled at t+1.

Result routing
- core_rvalid_o[occ[0].id] = apu_rvalid_i & occ[0].valid.
- core_result_o = apu_result_i and core_rflags_o = apu_rflags_i, unregistered.

Error detection
- apu_rvalid_i != occ[0].valid sets protocol_err_o, which is sticky until reset.
- An unexpected result is not routed to any core.

Reset
- All table entries invalid, rr_ptr = 0, protocol_err_o = 0, stall_cnt_o = 0.
- All combinational outputs are 0 while the inputs are idle.
- Reset mid-operation discards in-flight reservations; results arriving after reset raise protocol_err_o.

Optional Feature:
CV32E40P_APU_ARB_PERF_EN
- Defined: stall_cnt_o increments by 1 each cycle in which at least one core requests and none is granted. It saturates at 0xFFFFFFFF.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package cv32e40p_apu_core_pkg gains:
  - APU_LAT_CLASS enum (ADDSUB = 0, MULT = 1, CAST = 2, MAC = 3).
  - APU_MAX_LAT constant.
  - Class-to-latency function built on the PIPE_REG_* constants.
- One sub-module: cv32e40p_apu_rr_picker. It is a combinational rotate-priority picker with the eligibility mask and rr_ptr as inputs and winner index plus valid as outputs.
- The reservation table stays in the top module.

Test Plan:
1. Single req: core 1 addsub at t0 -> gnt[1] at t0; APU returns at t1 -> core_rvalid_o = 0010 at t1, result passes through unchanged.
2. All 4 cores request addsub continuously from rr_ptr = 0 -> grants in order 0, 1, 2, 3, 0, one per cycle, no stall.
3. Core 0 mac at t0, core 1 addsub at t1 -> core 1 blocked at t1 (slot t2 taken) and granted at t2; results core 0 at t2, core 1 at t3.
4. Core 2 mac and core 3 mult both requesting, rr_ptr = 3 -> core 3 granted; core 2 granted the next cycle; results at t+1 (core 3) and t+3 (core 2).
5. apu_rvalid_i pulsed with an empty table -> protocol_err_o = 1, no core_rvalid_o; stays 1 until rst_n low.
6. rst_n asserted low with a mac in flight -> occ cleared and rr_ptr = 0; with the perf macro, stall_cnt_o = 0 and it counts 1 per fully blocked request cycle afterwards.

Source files
------------

// File: rtl/cv32e40p_apu_core_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
// Shared APU definitions for the cluster shared-FPU path. It holds the
// CPU-side interface widths, the per-class pipeline depths, the latency-class
// enum, the longest result latency, and a class-to-latency helper.
// ---------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;

    // CPU-side APU interface widths
    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    // Pipeline register depth of each FPU operation group
    localparam int unsigned PIPE_REG_ADDSUB = 1;
    localparam int unsigned PIPE_REG_MULT   = 1;
    localparam int unsigned PIPE_REG_CAST   = 1;
    localparam int unsigned PIPE_REG_MAC    = 2;

    // Longest issue-to-result latency of any class
    localparam int unsigned APU_MAX_LAT = 2;

    typedef enum logic [1:0] {
        ADDSUB = 2'd0,
        MULT   = 2'd1,
        CAST   = 2'd2,
        MAC    = 2'd3
    } apu_lat_class_e;

    // Issue-to-result latency in cycles for a latency class
    function automatic logic [1:0] apu_class_lat(input apu_lat_class_e cls);
        logic [1:0] lat;
        case (cls)
            ADDSUB:  lat = 2'(PIPE_REG_ADDSUB);
            MULT:    lat = 2'(PIPE_REG_MULT);
            CAST:    lat = 2'(PIPE_REG_CAST);
            MAC:     lat = 2'(PIPE_REG_MAC);
            default: lat = 2'(PIPE_REG_ADDSUB);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/cv32e40p_apu_rr_picker.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_rr_picker
// Combinational rotate-priority picker. It returns the first set bit of
// 'eligible', scanning upward from rr_ptr and wrapping modulo N.
// Ports:
//   eligible     : per-requester eligibility mask
//   rr_ptr       : index that has the highest priority this cycle
//   winner       : index of the chosen requester (0 when none)
//   winner_valid : at least one requester is eligible
// ---------------------------------------------------------------------------
module cv32e40p_apu_rr_picker #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] rr_ptr,
    output logic [IDW-1:0] winner,
    output logic           winner_valid
);

    // Scan from the lowest priority to the highest so the nearest eligible
    // index at or after rr_ptr is the one that remains
    always_comb begin
        int idx;
        winner       = '0;
        winner_valid = 1'b0;
        idx          = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx          = (int'(rr_ptr) + k) % N;
            winner       = eligible[idx] ? IDW'(idx) : winner;
            winner_valid = winner_valid | eligible[idx];
        end
    end

endmodule

// File: rtl/cv32e40p_apu_shared_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_shared_arbiter
// Shares one fixed-latency APU pipeline between NB_CORES requesters. It uses
// round-robin arbitration and grants in the same cycle as the request. A
// reservation table claims the single result-port slot for each issue, so two
// results never collide, and it routes each result back to the core that
// issued it.
// Optional feature: define CV32E40P_APU_ARB_PERF_EN to enable the
// conflict-stall counter. When the macro is undefined, stall_cnt_o reads 0.
// Ports:
//   core_*_i / core_gnt_o : per-core request side (packed, core i at slice i)
//   core_rvalid_o         : one-hot result valid towards the issuing core
//   core_result_o/rflags  : APU result, broadcast, unregistered
//   apu_*_o               : muxed request to the shared APU
//   apu_rvalid_i/result_i : APU result port
//   protocol_err_o        : sticky, the APU result valid disagreed with the table
//   stall_cnt_o           : cycles with requests but no grant (optional)
// ---------------------------------------------------------------------------
module cv32e40p_apu_shared_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int NB_CORES = 4,
    parameter int NARGS    = APU_NARGS_CPU,
    parameter int WOP      = APU_WOP_CPU,
    parameter int NDSFLAGS = APU_NDSFLAGS_CPU,
    parameter int NUSFLAGS = APU_NUSFLAGS_CPU
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NB_CORES-1:0]          core_req_i,
    output logic [NB_CORES-1:0]          core_gnt_o,
    input  logic [2*NB_CORES-1:0]        core_lat_class_i,
    input  logic [WOP*NB_CORES-1:0]      core_op_i,
    input  logic [32*NARGS*NB_CORES-1:0] core_operands_i,
    input  logic [NDSFLAGS*NB_CORES-1:0] core_flags_i,
    output logic [NB_CORES-1:0]          core_rvalid_o,
    output logic [31:0]                  core_result_o,
    output logic [NUSFLAGS-1:0]          core_rflags_o,
    output logic                         apu_req_o,
    output logic [WOP-1:0]               apu_op_o,
    output logic [1:0]                   apu_lat_class_o,
    output logic [32*NARGS-1:0]          apu_operands_o,
    output logic [NDSFLAGS-1:0]          apu_flags_o,
    input  logic                         apu_rvalid_i,
    input  logic [31:0]                  apu_result_i,
    input  logic [NUSFLAGS-1:0]          apu_rflags_i,
    output logic                         protocol_err_o,
    output logic [31:0]                  stall_cnt_o
);

    localparam int ID_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int OPW  = 32 * NARGS;

    // occ_*_r[k]: a result is due k cycles from now, owned by occ_id_r[k]
    logic [APU_MAX_LAT:0] occ_valid_r;
    logic [ID_W-1:0]      occ_id_r [0:APU_MAX_LAT];

    logic [ID_W-1:0]      rr_ptr_r;
    logic                 protocol_err_r;

    logic [1:0]           core_lat_s [NB_CORES];
    logic [NB_CORES-1:0]  slot_busy_s;
    logic [NB_CORES-1:0]  elig_s;
    logic [NB_CORES-1:0]  gnt_s;
    logic [ID_W-1:0]      win_idx_s;
    logic                 win_valid_s;
    logic [1:0]           win_lat_s;

    // Eligibility: a core may issue only if its result slot is still free.
    // A core with latency L looks at occ[L]. After the shift, that entry becomes
    // occ[L-1], which is the entry this issue would claim.
    always_comb begin
        for (int i = 0; i < NB_CORES; i++) begin
            core_lat_s[i]  = apu_class_lat(apu_lat_class_e'(core_lat_class_i[2*i +: 2]));
            slot_busy_s[i] = 1'b0;
            for (int k = 0; k <= int'(APU_MAX_LAT); k++) begin
                slot_busy_s[i] = slot_busy_s[i] |
                                 ((int'(core_lat_s[i]) == k) & occ_valid_r[k]);
            end
            elig_s[i] = core_req_i[i] & ~slot_busy_s[i];
        end
    end

    cv32e40p_apu_rr_picker #(
        .N   (NB_CORES),
        .IDW (ID_W)
    ) u_picker (
        .eligible     (elig_s),
        .rr_ptr       (rr_ptr_r),
        .winner       (win_idx_s),
        .winner_valid (win_valid_s)
    );

    // One-hot grant and AND-OR request mux; everything is zero with no winner
    always_comb begin
        apu_op_o        = '0;
        apu_lat_class_o = 2'd0;
        apu_operands_o  = '0;
        apu_flags_o     = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            gnt_s[i]        = win_valid_s & (win_idx_s == ID_W'(i));
            apu_op_o        = apu_op_o | ({WOP{gnt_s[i]}} & core_op_i[WOP*i +: WOP]);
            apu_lat_class_o = apu_lat_class_o | ({2{gnt_s[i]}} & core_lat_class_i[2*i +: 2]);
            apu_operands_o  = apu_operands_o | ({OPW{gnt_s[i]}} & core_operands_i[OPW*i +: OPW]);
            apu_flags_o     = apu_flags_o | ({NDSFLAGS{gnt_s[i]}} & core_flags_i[NDSFLAGS*i +: NDSFLAGS]);
        end
        win_lat_s = apu_class_lat(apu_lat_class_e'(apu_lat_class_o));
    end

    assign core_gnt_o = gnt_s;
    assign apu_req_o  = win_valid_s;

    // Route a result only when the table expects one this cycle
    always_comb begin
        for (int i = 0; i < NB_CORES; i++) begin
            core_rvalid_o[i] = apu_rvalid_i & occ_valid_r[0] & (occ_id_r[0] == ID_W'(i));
        end
    end

    assign core_result_o = apu_result_i;
    assign core_rflags_o = apu_rflags_i;

    // Reservation table: shift toward occ[0] every cycle and claim occ'[L-1] on issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_valid_r <= '0;
            for (int k = 0; k <= int'(APU_MAX_LAT); k++) begin
                occ_id_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(APU_MAX_LAT); k++) begin
                occ_valid_r[k] <= occ_valid_r[k+1];
                occ_id_r[k]    <= occ_id_r[k+1];
            end
            occ_valid_r[APU_MAX_LAT] <= 1'b0;
            occ_id_r[APU_MAX_LAT]    <= '0;
            for (int k = 0; k <= int'(APU_MAX_LAT); k++) begin
                if (win_valid_s && (int'(win_lat_s) == k + 1)) begin
                    occ_valid_r[k] <= 1'b1;
                    occ_id_r[k]    <= win_idx_s;
                end else begin
                    occ_valid_r[k] <= (k < int'(APU_MAX_LAT)) ? occ_valid_r[k+1] : 1'b0;
                    occ_id_r[k]    <= (k < int'(APU_MAX_LAT)) ? occ_id_r[k+1] : '0;
                end
            end
        end
    end

    // Round-robin pointer moves just past the winner, and only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (win_valid_s) begin
            rr_ptr_r <= (win_idx_s == ID_W'(NB_CORES - 1)) ? '0 : win_idx_s + ID_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Sticky error: a result arrived unannounced, or an expected one is missing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err_r <= 1'b0;
        end else begin
            protocol_err_r <= protocol_err_r | (apu_rvalid_i != occ_valid_r[0]);
        end
    end

    assign protocol_err_o = protocol_err_r;

`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where someone requests but nobody is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if ((|core_req_i) && !win_valid_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_shared_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_apu_shared_arbiter
// Directed test of the shared APU arbiter: reset state, round-robin order,
// request muxing, result routing, slot-conflict stalls, the protocol error
// flag, mid-flight reset and (when enabled) the stall counter.
// ---------------------------------------------------------------------------
module tb_cv32e40p_apu_shared_arbiter;

    localparam int NB  = 4;
    localparam int NA  = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;

    logic                   clk;
    logic                   rst_n;
    logic [NB-1:0]          core_req;
    logic [NB-1:0]          core_gnt;
    logic [2*NB-1:0]        core_lat_class;
    logic [WOP*NB-1:0]      core_op;
    logic [32*NA*NB-1:0]    core_operands;
    logic [NDS*NB-1:0]      core_flags;
    logic [NB-1:0]          core_rvalid;
    logic [31:0]            core_result;
    logic [NUS-1:0]         core_rflags;
    logic                   apu_req;
    logic [WOP-1:0]         apu_op;
    logic [1:0]             apu_lat_class;
    logic [32*NA-1:0]       apu_operands;
    logic [NDS-1:0]         apu_flags;
    logic                   apu_rvalid;
    logic [31:0]            apu_result;
    logic [NUS-1:0]         apu_rflags;
    logic                   protocol_err;
    logic [31:0]            stall_cnt;

    int total = 0;
    int bad   = 0;

    cv32e40p_apu_shared_arbiter #(
        .NB_CORES (NB),
        .NARGS    (NA),
        .WOP      (WOP),
        .NDSFLAGS (NDS),
        .NUSFLAGS (NUS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .core_req_i       (core_req),
        .core_gnt_o       (core_gnt),
        .core_lat_class_i (core_lat_class),
        .core_op_i        (core_op),
        .core_operands_i  (core_operands),
        .core_flags_i     (core_flags),
        .core_rvalid_o    (core_rvalid),
        .core_result_o    (core_result),
        .core_rflags_o    (core_rflags),
        .apu_req_o        (apu_req),
        .apu_op_o         (apu_op),
        .apu_lat_class_o  (apu_lat_class),
        .apu_operands_o   (apu_operands),
        .apu_flags_o      (apu_flags),
        .apu_rvalid_i     (apu_rvalid),
        .apu_result_i     (apu_result),
        .apu_rflags_i     (apu_rflags),
        .protocol_err_o   (protocol_err),
        .stall_cnt_o      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected stall count: real count with the perf feature, 0 without it
    function automatic logic [127:0] sx(input int n);
`ifdef CV32E40P_APU_ARB_PERF_EN
        return 128'(n);
`else
        return 128'd0 + 128'(n * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        core_req       = '0;
        core_lat_class = '0;
        core_op        = '0;
        core_operands  = '0;
        core_flags     = '0;
        apu_rvalid     = 1'b0;
        apu_result     = 32'd0;
        apu_rflags     = '0;
    endtask

    task automatic set_core(input int i, input logic [1:0] cls, input logic [5:0] op,
                            input logic [95:0] opnd, input logic [14:0] fl);
        core_req[i]               = 1'b1;
        core_lat_class[2*i +: 2]  = cls;
        core_op[6*i +: 6]         = op;
        core_operands[96*i +: 96] = opnd;
        core_flags[15*i +: 15]    = fl;
    endtask

    // move to the next cycle: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle; samples land mid-cycle
    task automatic settle();
        #4;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_gnt",    128'(core_gnt),     128'd0);
        chk("rst_req",    128'(apu_req),      128'd0);
        chk("rst_rvalid", 128'(core_rvalid),  128'd0);
        chk("rst_err",    128'(protocol_err), 128'd0);
        chk("rst_stall",  128'(stall_cnt),    128'd0);
        chk("rst_op",     128'(apu_op),       128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // all four cores request addsub continuously: grants 0,1,2,3,0
        for (int c = 0; c < 5; c++) begin
            tick();
            idle();
            for (int i = 0; i < NB; i++) set_core(i, 2'd0, 6'(6'h10 + i), 96'(i), 15'(i));
            apu_rvalid = (c > 0);
            settle();
            chk("rr_gnt", 128'(core_gnt), 128'd1 << (c % 4));
            chk("rr_op",  128'(apu_op),   128'(6'h10 + (c % 4)));
            if (c > 0) chk("rr_rvalid", 128'(core_rvalid), 128'd1 << ((c - 1) % 4));
        end
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("rr_last_rvalid", 128'(core_rvalid), 128'h1);
        chk("rr_idle_gnt",    128'(core_gnt),    128'h0);

        // single addsub request from core 1; result routed back next cycle
        tick();
        idle();
        set_core(1, 2'd0, 6'h15, 96'h1111_2222_3333_4444_5555_6666, 15'h1234);
        settle();
        chk("s_gnt",   128'(core_gnt),      128'h2);
        chk("s_req",   128'(apu_req),       128'h1);
        chk("s_op",    128'(apu_op),        128'h15);
        chk("s_opnd",  128'(apu_operands),  128'h1111_2222_3333_4444_5555_6666);
        chk("s_flags", 128'(apu_flags),     128'h1234);
        chk("s_class", 128'(apu_lat_class), 128'h0);
        tick();
        idle();
        apu_rvalid = 1'b1;
        apu_result = 32'hDEAD_BEEF;
        apu_rflags = 5'h1A;
        settle();
        chk("s_rvalid", 128'(core_rvalid), 128'h2);
        chk("s_result", 128'(core_result), 128'hDEAD_BEEF);
        chk("s_rflags", 128'(core_rflags), 128'h1A);
        tick();
        idle();
        settle();
        chk("s_err", 128'(protocol_err), 128'h0);

        // core 0 mac then core 1 addsub: addsub stalled one cycle
        tick();
        idle();
        set_core(0, 2'd3, 6'h21, 96'hA, 15'h1);
        settle();
        chk("mac_gnt",   128'(core_gnt),      128'h1);
        chk("mac_class", 128'(apu_lat_class), 128'h3);
        tick();
        idle();
        set_core(1, 2'd0, 6'h22, 96'hB, 15'h2);
        settle();
        chk("blk_gnt", 128'(core_gnt), 128'h0);
        chk("blk_req", 128'(apu_req),  128'h0);
        tick();
        idle();
        set_core(1, 2'd0, 6'h22, 96'hB, 15'h2);
        apu_rvalid = 1'b1;
        settle();
        chk("mac_rvalid", 128'(core_rvalid), 128'h1);
        chk("blk_gnt2",   128'(core_gnt),    128'h2);
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("add_rvalid", 128'(core_rvalid), 128'h2);
        chk("stall_one",  128'(stall_cnt),   sx(1));

        // bring rr_ptr to 3 via a core 2 grant
        tick();
        idle();
        set_core(2, 2'd0, 6'h23, 96'hC, 15'h3);
        settle();
        chk("p3_gnt", 128'(core_gnt), 128'h4);
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("p3_rvalid", 128'(core_rvalid), 128'h4);

        // core 2 mac and core 3 mult, rr_ptr = 3: core 3 first, core 2 next
        tick();
        idle();
        set_core(2, 2'd3, 6'h24, 96'hD, 15'h4);
        set_core(3, 2'd1, 6'h25, 96'hE, 15'h5);
        settle();
        chk("t4_gnt3",  128'(core_gnt),      128'h8);
        chk("t4_class", 128'(apu_lat_class), 128'h1);
        tick();
        idle();
        set_core(2, 2'd3, 6'h24, 96'hD, 15'h4);
        apu_rvalid = 1'b1;
        settle();
        chk("t4_rv3",   128'(core_rvalid), 128'h8);
        chk("t4_gnt2",  128'(core_gnt),    128'h4);
        tick();
        idle();
        settle();
        chk("t4_gap",   128'(core_rvalid), 128'h0);
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("t4_rv2",   128'(core_rvalid),  128'h4);
        chk("t4_err",   128'(protocol_err), 128'h0);

        // unexpected result with an empty table
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("err_rvalid", 128'(core_rvalid),  128'h0);
        chk("err_pre",    128'(protocol_err), 128'h0);
        tick();
        idle();
        settle();
        chk("err_set", 128'(protocol_err), 128'h1);
        tick();
        tick();
        settle();
        chk("err_sticky", 128'(protocol_err), 128'h1);

        // reset with a mac in flight
        tick();
        idle();
        set_core(0, 2'd3, 6'h26, 96'hF, 15'h6);
        settle();
        chk("r_mac_gnt", 128'(core_gnt), 128'h1);
        tick();
        idle();
        rst_n = 1'b0;
        settle();
        chk("r_err",    128'(protocol_err), 128'h0);
        chk("r_stall",  128'(stall_cnt),    128'h0);
        chk("r_rvalid", 128'(core_rvalid),  128'h0);
        rst_n = 1'b1;
        tick();
        idle();
        for (int i = 0; i < NB; i++) set_core(i, 2'd0, 6'(6'h30 + i), 96'(i), 15'(i));
        apu_rvalid = 1'b1;
        settle();
        chk("r_discard", 128'(core_rvalid), 128'h0);
        chk("r_ptr0",    128'(core_gnt),    128'h1);
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("r_rv0",     128'(core_rvalid),  128'h1);
        chk("r_err_set", 128'(protocol_err), 128'h1);

        // a stall after reset counts from zero
        tick();
        idle();
        set_core(0, 2'd3, 6'h27, 96'h10, 15'h7);
        settle();
        chk("r2_gnt0", 128'(core_gnt), 128'h1);
        tick();
        idle();
        set_core(1, 2'd0, 6'h28, 96'h11, 15'h8);
        settle();
        chk("r2_blk", 128'(core_gnt), 128'h0);
        tick();
        idle();
        set_core(1, 2'd0, 6'h28, 96'h11, 15'h8);
        apu_rvalid = 1'b1;
        settle();
        chk("r2_gnt1",  128'(core_gnt),    128'h2);
        chk("r2_rv0",   128'(core_rvalid), 128'h1);
        chk("r2_stall", 128'(stall_cnt),   sx(1));
        tick();
        idle();
        apu_rvalid = 1'b1;
        settle();
        chk("r2_rv1", 128'(core_rvalid), 128'h2);
        tick();
        idle();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
